channel_sample_n: RTL
=====================

Name: channel_sample_n

Overview:
Parametrised multi-channel successor to the per-channel sampler. It takes NUM_CH pairs of AFE comparator outputs (CH_H/CH_L) and synchronises each pair into the clk domain. On a sample strobe, optionally decimated, it captures the pairs and packs SMPL_PER_WORD successive captures per channel into one wide word. The word is handed to the capture RAM/trigger logic over a valid/ready handshake, with overrun detection.

Parameters:
NUM_CH, 5, number of analog channels (1..16)
SMPL_PER_WORD, 4, H/L pairs packed per channel per word (1..8); per-channel field width W = 2*SMPL_PER_WORD
SYNC_STAGES, 2, synchroniser depth on CH_H/CH_L (2..4)
DEC_W, 4, width of decimation control

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
CH_H  in  NUM_CH  high-threshold comparator outputs, asynchronous
CH_L  in  NUM_CH  low-threshold comparator outputs, asynchronous
run  in  1  capture enable; low holds counters and clears the partial word
smpl_en  in  1  one-cycle sample strobe (from clk_rst_smpl)
decimator  in  DEC_W  capture on every (decimator+1)th smpl_en
smpl  out  NUM_CH*W  packed word; channel c in bits [c*W +: W]
smpl_vld  out  1  smpl holds an unconsumed word
smpl_rdy  in  1  consumer accepts word when smpl_vld&&smpl_rdy
ovr  out  1  sticky overrun flag
clr_ovr  in  1  clears ovr

Behaviour:
- Reset (rst=1 at posedge clk): all synchroniser flops, pack registers, smpl=0, smpl_vld=0, ovr=0, dec_cnt=0, pack_cnt=0.
- Synchronisers clock every clk, ungated. A change on CH_H/CH_L is visible at the last stage SYNC_STAGES clks later.
- Decimation: dec_cnt increments on each smpl_en while run=1. A capture occurs on smpl_en when dec_cnt >= decimator, and dec_cnt then returns to 0. A smaller decimator written mid-run therefore captures on the next smpl_en.
- Capture: the pack register shifts left by 2 per channel and inserts {H,L} from the last sync stage at bits [1:0]. The newest pair is at LSBs; pair k (k=0 newest) has H at bit 2k+1 and L at bit 2k. pack_cnt increments modulo SMPL_PER_WORD.
- Word completion: a capture with pack_cnt==SMPL_PER_WORD-1 completes a word.
  - If the holding register is free, or being consumed in the same cycle (smpl_vld&&smpl_rdy), the word including the completing pair loads into smpl. smpl_vld is 1 the next clk, i.e. 1 clk latency from the completing strobe.
  - Otherwise the new word is dropped, smpl is unchanged, and ovr is set.
- Handshake: smpl_vld falls the clk after smpl_vld&&smpl_rdy, unless a new word loads that same clk, in which case it stays 1 and smpl updates. smpl is stable while smpl_vld=1 and smpl_rdy=0.
- ovr is sticky until clr_ovr=1. If a set and clr_ovr coincide, the set wins.
- run=0: dec_cnt, pack_cnt and pack registers are held at 0, and a partial word is discarded. smpl/smpl_vld are unaffected, so a pending word can still be consumed. Capture restarts cleanly on the first smpl_en after run rises.
- rst mid-word or with a pending word: everything returns to reset values the next clk, and the pending word is lost.
- SMPL_PER_WORD=1: every capture completes a word.

Decomposition:
- Package channel_sample_pkg: MAX_CH, MAX_SPW constants and a function for field width W. It also defines typedef pair_t (struct {H,L}).
- Sub-module ch_sync: a SYNC_STAGES-deep 2-bit synchroniser, instantiated NUM_CH times via generate.
- Decimation, pack and handshake logic stay in the top.

Test Plan (NUM_CH=5, SMPL_PER_WORD=4, SYNC_STAGES=2, smpl_en every 4 clks, smpl_rdy=1 unless stated):
- CH1 H=1, L=0 held; others 0; decimator=0 -> after 4th capture, smpl_vld=1 one clk later, smpl[7:0]=8'hAA, other channels 8'h00.
- CH1 pairs (oldest to newest) {1,1},{0,0},{1,0},{0,1}, each stable >=3 clks before its strobe -> smpl[7:0]=8'hC9.
- smpl_rdy=0 for 2 word periods -> first word held unchanged, second dropped, ovr=1. Then rdy=1 plus clr_ovr -> ovr=0, third word delivered.
- Word completes in the same clk as smpl_vld&&smpl_rdy -> smpl_vld stays 1, smpl updates, ovr stays 0.
- decimator=3 -> captures on smpl_en #4,8,12,16; word after 16 strobes. Change decimator to 0 when dec_cnt=2 -> capture on next strobe.
- rst=1 for 1 clk after 2 captures -> all outputs 0. The next word needs 4 fresh captures. Repeat with run=0 instead of rst: pending smpl is kept, and the partial word is discarded.

Source files
------------

// File: rtl/channel_sample_pkg.sv
// Shared types and sizing helpers for the multi-channel comparator sampler.
package channel_sample_pkg;

    localparam int MAX_CH  = 16;
    localparam int MAX_SPW = 8;

    // One comparator pair as seen after synchronisation.
    typedef struct packed {
        logic h;
        logic l;
    } pair_t;

    function automatic int field_w(input int spw);
        return 32'sd2 * spw;
    endfunction

endpackage

// File: rtl/ch_sync.sv
// Multi-stage synchroniser for one H/L comparator pair into the clk domain.
module ch_sync
    import channel_sample_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  pair_t d,
    output pair_t q
);

    pair_t [SYNC_STAGES-1:0] stage_r;

    // Shift the asynchronous pair through the synchroniser chain every clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/channel_sample_n.sv
// Multi-channel comparator sampler: synchronise, decimate, pack pairs into
// words and hand them off over a valid/ready handshake with overrun flag.
module channel_sample_n
    import channel_sample_pkg::*;
#(
    parameter int NUM_CH        = 5,
    parameter int SMPL_PER_WORD = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEC_W         = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_CH-1:0]                        CH_H,
    input  logic [NUM_CH-1:0]                        CH_L,
    input  logic                                     run,
    input  logic                                     smpl_en,
    input  logic [DEC_W-1:0]                         decimator,
    output logic [NUM_CH*field_w(SMPL_PER_WORD)-1:0] smpl,
    output logic                                     smpl_vld,
    input  logic                                     smpl_rdy,
    output logic                                     ovr,
    input  logic                                     clr_ovr
);

    localparam int W      = field_w(SMPL_PER_WORD);
    localparam int WORD_W = NUM_CH * W;
    localparam int PCNT_W = $clog2(MAX_SPW) + 1;
    localparam logic [PCNT_W-1:0] LAST_PAIR = PCNT_W'(SMPL_PER_WORD - 1);

    pair_t [NUM_CH-1:0] raw_s;
    pair_t [NUM_CH-1:0] pair_s;

    logic [DEC_W-1:0]  dec_cnt_r;
    logic [PCNT_W-1:0] pack_cnt_r;
    logic [WORD_W-1:0] pack_r;
    logic [WORD_W-1:0] pack_next_s;
    logic [WORD_W-1:0] smpl_r;
    logic              smpl_vld_r;
    logic              ovr_r;

    logic capture_s;
    logic word_done_s;
    logic load_s;
    logic drop_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
        assign raw_s[c] = '{h: CH_H[c], l: CH_L[c]};

        ch_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch_sync (
            .clk (clk),
            .rst (rst),
            .d   (raw_s[c]),
            .q   (pair_s[c])
        );
    end

    // Decide whether this strobe captures and whether it closes a word.
    always_comb begin
        capture_s   = 1'b0;
        word_done_s = 1'b0;
        load_s      = 1'b0;
        drop_s      = 1'b0;
        if (run && smpl_en && (dec_cnt_r >= decimator)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        word_done_s = capture_s && (pack_cnt_r == LAST_PAIR);
        // A word in flight frees its slot in the same clk it is taken.
        if (word_done_s && (!smpl_vld_r || smpl_rdy)) begin
            load_s = 1'b1;
        end else if (word_done_s) begin
            drop_s = 1'b1;
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Per-channel shift: older pairs move up, newest pair lands at the LSBs.
    always_comb begin
        pack_next_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pack_next_s[c*W +: W] = (pack_r[c*W +: W] << 2'd2) | W'(pair_s[c]);
        end
    end

    // Decimation counter, pair counter and pack register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt_r  <= '0;
            pack_cnt_r <= '0;
            pack_r     <= '0;
        end else if (!run) begin
            dec_cnt_r  <= '0;
            pack_cnt_r <= '0;
            pack_r     <= '0;
        end else if (smpl_en) begin
            if (dec_cnt_r >= decimator) begin
                dec_cnt_r <= '0;
                pack_r    <= pack_next_s;
                if (pack_cnt_r == LAST_PAIR) begin
                    pack_cnt_r <= '0;
                end else begin
                    pack_cnt_r <= pack_cnt_r + PCNT_W'(1);
                end
            end else begin
                dec_cnt_r <= dec_cnt_r + DEC_W'(1);
            end
        end else begin
            dec_cnt_r  <= dec_cnt_r;
            pack_cnt_r <= pack_cnt_r;
            pack_r     <= pack_r;
        end
    end

    // Holding register and valid flag for the consumer handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            smpl_r     <= '0;
            smpl_vld_r <= 1'b0;
        end else if (load_s) begin
            smpl_r     <= pack_next_s;
            smpl_vld_r <= 1'b1;
        end else if (smpl_vld_r && smpl_rdy) begin
            smpl_r     <= smpl_r;
            smpl_vld_r <= 1'b0;
        end else begin
            smpl_r     <= smpl_r;
            smpl_vld_r <= smpl_vld_r;
        end
    end

    // Sticky overrun; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_r <= 1'b0;
        end else if (drop_s) begin
            ovr_r <= 1'b1;
        end else if (clr_ovr) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign smpl     = smpl_r;
    assign smpl_vld = smpl_vld_r;
    assign ovr      = ovr_r;

endmodule
